bank_burst_ctrl: RTL and testbench
==================================

// Module: bank_burst_ctrl
// PURPOSE
//  Command-side driver for one DRAM-emulation Bank array (the initiator to the Bank's storage responder).
//  Accepts ACT/RD/WR/PRE commands from the rank-level FSM, tracks the open row and enforces tRCD/tCL/tRP.
//  Sequences BL-beat bursts onto the Bank's row/column/rd_o_wr/dqin, and returns read beats with a valid strobe.
// PARAMETERS
//  DEVICE_WIDTH  4       DQ width per beat
//  ROWS          131072  rows per bank; row field is $clog2(ROWS) bits
//  COLS          1024    columns per row; col field is $clog2(COLS) bits
//  BL            8       burst length in beats; power of 2, 2..COLS
//  tRCD          4       ACT-to-RD/WR delay in clk cycles, >=1
//  tCL           4       RD-accept to first read address beat in cycles, >=1
//  tRP           4       PRE-to-idle delay in clk cycles, >=1
// PORTS
//  clk           in   1             clock
//  reset_n       in   1             asynchronous active-low reset
//  cmd_valid     in   1             command present
//  cmd_ready     out  1             command accepted when valid&&ready
//  cmd_op        in   2             00 ACT, 01 RD, 10 WR, 11 PRE
//  cmd_row       in   $clog2(ROWS)  row address, used by ACT only
//  cmd_col       in   $clog2(COLS)  start column, used by RD/WR only
//  wr_data       in   DEVICE_WIDTH  write beat, consumed when wr_data_req=1
//  wr_data_req   out  1             write beat consumed this cycle
//  rd_data       out  DEVICE_WIDTH  read beat
//  rd_valid      out  1             rd_data valid this cycle
//  cmd_err       out  1             one-cycle pulse: illegal command dropped
//  row_open      out  1             a row is active
//  bank_row      out  $clog2(ROWS)  to Bank row
//  bank_col      out  $clog2(COLS)  to Bank column
//  bank_rd_o_wr  out  1             to Bank: 0 read, 1 write
//  bank_dqin     out  DEVICE_WIDTH  to Bank write data (= wr_data during write beats)
//  bank_dqout    in   DEVICE_WIDTH  from Bank; synchronous read, valid 1 cycle after address
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; open-row register 0; counters 0. Async assert, sync release.
//  FSM: IDLE, ACTIVATING, ACTIVE, RD_WAIT, RD_BURST, WR_BURST, PRECHARGING.
//  cmd_ready=1 only in IDLE and ACTIVE. Otherwise commands stall; no queueing.
//  IDLE: ACT latches cmd_row into bank_row -> ACTIVATING, tRCD cycles -> ACTIVE.
//   PRE is accepted as a NOP. RD/WR: dropped, cmd_err=1 for one cycle, FSM remains in IDLE.
//  ACTIVE: RD -> RD_WAIT for tCL cycles, then RD_BURST. WR -> WR_BURST on the next cycle.
//   PRE -> PRECHARGING, tRP cycles -> IDLE; row_open falls on PRE accept.
//   ACT -> dropped, cmd_err=1.
//  Burst: exactly BL beats, one per cycle. Beat k column = {start[hi:log2 BL], (start[log2 BL-1:0]+k) mod BL}.
//   The column wraps inside the BL-aligned block and never carries into the upper bits.
//  RD_BURST: bank_rd_o_wr=0. rd_valid=1 one cycle after each address beat, with rd_data=bank_dqout.
//   rd_valid therefore spans BL consecutive cycles. After the last beat -> ACTIVE.
//  WR_BURST: bank_rd_o_wr=1 and wr_data_req=1 on every beat; bank_dqin=wr_data; after the last beat -> ACTIVE.
//  Outside WR_BURST, bank_rd_o_wr=0 (the Bank is never written spuriously) and bank_col holds its last value.
//  Back-to-back: cmd_ready returns 1 the cycle after the last beat. The last read's rd_valid can overlap
//   the next command's accept.
//  Reset mid-burst: abort immediately. Remaining beats and pending rd_valid are discarded; the row closes.
//  Timer counters are sized $clog2(max(tRCD,tCL,tRP)+1) bits and are loaded with (t-1) on entry.
// STRUCTURE
//  Package ddr_bank_pkg: cmd_op encodings (OP_ACT/OP_RD/OP_WR/OP_PRE) and the FSM state enum.
//  Sub-module burst_col_gen: loads the start column, steps the wrapped column per beat, flags the last beat.
// TESTING
//  ACT row 5 at t0 -> cmd_ready=0 for tRCD=4 cycles; row_open=1; bank_row=5.
//  RD col 13, BL=8 -> after tCL, bank_col = 13,14,15,8,9,10,11,12; rd_valid high 8 cycles, lagging 1.
//  WR col 0, wr_data=1..8 -> bank_rd_o_wr=1 for 8 cycles, cols 0..7; readback RD col 0 returns 1..8.
//  RD issued in IDLE -> cmd_err pulse of 1 cycle; no bank_rd_o_wr or rd_valid activity; state stays IDLE.
//  Drop reset_n in beat 3 of a WR burst -> bank_rd_o_wr=0 at once; row_open=0; cmd_ready=1 after release.
//  PRE then ACT row 9 -> ACT stalls tRP=4 cycles, is then accepted; row_open=1; bank_row=9.

Source files
------------

// File: rtl/ddr_bank_pkg.sv
// ddr_bank_pkg: shared encodings for the bank burst controller.
// Command op codes, FSM states and a timer sizing helper.
package ddr_bank_pkg;

    localparam logic [1:0] OP_ACT = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;
    localparam logic [1:0] OP_PRE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVATING,
        ST_ACTIVE,
        ST_RD_WAIT,
        ST_RD_BURST,
        ST_WR_BURST,
        ST_PRECHARGING
    } bank_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/burst_col_gen.sv
// burst_col_gen: per-beat column stepping for one burst.
// Wraps inside the BL-aligned block and flags the last beat.
module burst_col_gen
    import ddr_bank_pkg::*;
#(
    parameter int COL_W = 10,
    parameter int BL    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [COL_W-1:0] start,
    output logic [COL_W-1:0] col,
    output logic             last
);

    localparam int OFF_W = $clog2(BL);

    logic [OFF_W-1:0] beat;
    logic [COL_W-1:0] col_next;

    if (OFF_W < COL_W) begin : g_split
        assign col_next = {col[COL_W-1:OFF_W],
                           col[OFF_W-1:0] + OFF_W'(1)};
    end else begin : g_full
        assign col_next = col + COL_W'(1);
    end

    assign last = (beat == OFF_W'(BL - 1));

    // Column and beat index: load at burst start, advance per beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col  <= '0;
            beat <= '0;
        end else if (load) begin
            col  <= start;
            beat <= '0;
        end else if (step) begin
            col  <= col_next;
            beat <= beat + OFF_W'(1);
        end
    end

endmodule

// File: rtl/bank_burst_ctrl.sv
// bank_burst_ctrl: command-side driver for one emulated DRAM bank.
// Tracks the open row, enforces tRCD/tCL/tRP and sequences bursts.
module bank_burst_ctrl
    import ddr_bank_pkg::*;
#(
    parameter int DEVICE_WIDTH = 4,
    parameter int ROWS         = 131072,
    parameter int COLS         = 1024,
    parameter int BL           = 8,
    parameter int tRCD         = 4,
    parameter int tCL          = 4,
    parameter int tRP          = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [$clog2(ROWS)-1:0]  cmd_row,
    input  logic [$clog2(COLS)-1:0]  cmd_col,
    input  logic [DEVICE_WIDTH-1:0]  wr_data,
    output logic                     wr_data_req,
    output logic [DEVICE_WIDTH-1:0]  rd_data,
    output logic                     rd_valid,
    output logic                     cmd_err,
    output logic                     row_open,
    output logic [$clog2(ROWS)-1:0]  bank_row,
    output logic [$clog2(COLS)-1:0]  bank_col,
    output logic                     bank_rd_o_wr,
    output logic [DEVICE_WIDTH-1:0]  bank_dqin,
    input  logic [DEVICE_WIDTH-1:0]  bank_dqout
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int TW    = $clog2(max3(tRCD, tCL, tRP) + 1);

    bank_state_e      state;
    logic [TW-1:0]    tmr;
    logic [COL_W-1:0] start_col;
    logic             accept;
    logic             col_load;
    logic             col_step;
    logic             col_last;
    logic [COL_W-1:0] col_start;

    assign accept = cmd_valid && cmd_ready;

    // Read data is only presented while its strobe is up.
    assign rd_data   = rd_valid ? bank_dqout : '0;
    assign bank_dqin = bank_rd_o_wr ? wr_data : '0;

    // Column generator control: writes start next cycle, reads after tCL.
    always_comb begin
        col_load  = 1'b0;
        col_step  = 1'b0;
        col_start = start_col;
        if (state == ST_ACTIVE && accept && cmd_op == OP_WR) begin
            col_load  = 1'b1;
            col_start = cmd_col;
        end
        if (state == ST_RD_WAIT && tmr == '0) begin
            col_load = 1'b1;
        end
        if ((state == ST_RD_BURST || state == ST_WR_BURST) && !col_last) begin
            col_step = 1'b1;
        end
    end

    burst_col_gen #(
        .COL_W (COL_W),
        .BL    (BL)
    ) u_col_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (col_load),
        .step    (col_step),
        .start   (col_start),
        .col     (bank_col),
        .last    (col_last)
    );

    // Bank FSM with registered handshake, strobe and bank-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            tmr          <= '0;
            start_col    <= '0;
            cmd_ready    <= 1'b0;
            cmd_err      <= 1'b0;
            row_open     <= 1'b0;
            bank_row     <= '0;
            bank_rd_o_wr <= 1'b0;
            wr_data_req  <= 1'b0;
            rd_valid     <= 1'b0;
        end else begin
            cmd_err  <= 1'b0;
            rd_valid <= (state == ST_RD_BURST);
            unique case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        unique case (cmd_op)
                            OP_ACT: begin
                                bank_row  <= cmd_row;
                                row_open  <= 1'b1;
                                tmr       <= TW'(tRCD - 1);
                                cmd_ready <= 1'b0;
                                state     <= ST_ACTIVATING;
                            end
                            OP_PRE: ;
                            OP_RD, OP_WR: cmd_err <= 1'b1;
                        endcase
                    end
                end
                ST_ACTIVATING: begin
                    if (tmr == '0) begin
                        cmd_ready <= 1'b1;
                        state     <= ST_ACTIVE;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (accept) begin
                        unique case (cmd_op)
                            OP_RD: begin
                                start_col <= cmd_col;
                                tmr       <= TW'(tCL - 1);
                                cmd_ready <= 1'b0;
                                state     <= ST_RD_WAIT;
                            end
                            OP_WR: begin
                                bank_rd_o_wr <= 1'b1;
                                wr_data_req  <= 1'b1;
                                cmd_ready    <= 1'b0;
                                state        <= ST_WR_BURST;
                            end
                            OP_PRE: begin
                                row_open  <= 1'b0;
                                tmr       <= TW'(tRP - 1);
                                cmd_ready <= 1'b0;
                                state     <= ST_PRECHARGING;
                            end
                            OP_ACT: cmd_err <= 1'b1;
                        endcase
                    end
                end
                ST_RD_WAIT: begin
                    if (tmr == '0) begin
                        state <= ST_RD_BURST;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                ST_RD_BURST: begin
                    if (col_last) begin
                        cmd_ready <= 1'b1;
                        state     <= ST_ACTIVE;
                    end
                end
                ST_WR_BURST: begin
                    if (col_last) begin
                        bank_rd_o_wr <= 1'b0;
                        wr_data_req  <= 1'b0;
                        cmd_ready    <= 1'b1;
                        state        <= ST_ACTIVE;
                    end
                end
                ST_PRECHARGING: begin
                    if (tmr == '0) begin
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                default: begin
                    cmd_ready <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bank_burst_ctrl.sv
// tb_bank_burst_ctrl: directed bench for bank_burst_ctrl.
// A small bank model answers reads one cycle after the address.
module tb_bank_burst_ctrl;
    import ddr_bank_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [16:0] cmd_row;
    logic [9:0]  cmd_col;
    logic [3:0]  wr_data;
    logic        wr_data_req;
    logic [3:0]  rd_data;
    logic        rd_valid;
    logic        cmd_err;
    logic        row_open;
    logic [16:0] bank_row;
    logic [9:0]  bank_col;
    logic        bank_rd_o_wr;
    logic [3:0]  bank_dqin;
    logic [3:0]  bank_dqout;

    int n_assert;
    int n_fail;

    logic [3:0] mem [1024];
    bit         written [1024];
    logic [9:0] exp_col [8];
    logic [3:0] exp_dat [8];

    bank_burst_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_row      (cmd_row),
        .cmd_col      (cmd_col),
        .wr_data      (wr_data),
        .wr_data_req  (wr_data_req),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .cmd_err      (cmd_err),
        .row_open     (row_open),
        .bank_row     (bank_row),
        .bank_col     (bank_col),
        .bank_rd_o_wr (bank_rd_o_wr),
        .bank_dqin    (bank_dqin),
        .bank_dqout   (bank_dqout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] init_val(input logic [9:0] c);
        return 4'((c * 7) + 3);
    endfunction

    // Bank storage: synchronous read, write when bank_rd_o_wr is high.
    always @(posedge clk) begin
        if (bank_rd_o_wr) begin
            mem[bank_col]     <= bank_dqin;
            written[bank_col] <= 1'b1;
        end
        bank_dqout <= written[bank_col] ? mem[bank_col] : init_val(bank_col);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [16:0] row,
                        input logic [9:0] col);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = row;
        cmd_col   = col;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] col);
        int first;
        int nv;
        first = -1;
        nv    = 0;
        send(OP_RD, 17'd0, col);
        for (int i = 0; i < 16; i++) begin
            if (i >= 4 && i < 12) chk("rd_col", bank_col, exp_col[i-4]);
            chk("rd_no_write", bank_rd_o_wr, 0);
            if (rd_valid) begin
                if (first < 0) first = i;
                if (nv < 8) chk("rd_data", rd_data, exp_dat[nv]);
                nv++;
            end
            if (i == 11) chk("rd_busy_last", cmd_ready, 0);
            if (i == 12) chk("rd_ready_back", cmd_ready, 1);
            @(negedge clk);
        end
        chk("rd_first_valid", first, 5);
        chk("rd_beats", nv, 8);
    endtask

    initial begin
        int  cnt;
        bit  seen;
        n_assert  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_row   = '0;
        cmd_col   = '0;
        wr_data   = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_row_open", row_open, 0);
        chk("rst_bank_row", bank_row, 0);
        chk("rst_bank_col", bank_col, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr", bank_rd_o_wr, 0);
        chk("rst_err", cmd_err, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", cmd_ready, 1);

        send(OP_PRE, 17'd0, 10'd0);
        chk("pre_idle_err", cmd_err, 0);
        chk("pre_idle_ready", cmd_ready, 1);
        chk("pre_idle_row", row_open, 0);

        send(OP_RD, 17'd0, 10'd3);
        chk("rd_idle_err", cmd_err, 1);
        chk("rd_idle_ready", cmd_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rd_valid || bank_rd_o_wr || cmd_err || !cmd_ready) seen = 1'b1;
        end
        chk("rd_idle_quiet", seen, 0);

        send(OP_ACT, 17'd5, 10'd0);
        chk("act_ready", cmd_ready, 0);
        chk("act_row_open", row_open, 1);
        chk("act_bank_row", bank_row, 5);
        cnt = 1;
        while (!cmd_ready && cnt < 20) begin
            @(negedge clk);
            if (!cmd_ready) cnt++;
        end
        chk("act_trcd", cnt, 4);

        send(OP_ACT, 17'd2, 10'd0);
        chk("act_active_err", cmd_err, 1);
        chk("act_active_row", bank_row, 5);
        chk("act_active_ready", cmd_ready, 1);

        exp_col = '{10'd13, 10'd14, 10'd15, 10'd8,
                    10'd9, 10'd10, 10'd11, 10'd12};
        for (int k = 0; k < 8; k++) exp_dat[k] = init_val(exp_col[k]);
        do_read(10'd13);

        send(OP_WR, 17'd0, 10'd0);
        for (int k = 0; k < 8; k++) begin
            chk("wr_req", wr_data_req, 1);
            chk("wr_dir", bank_rd_o_wr, 1);
            chk("wr_col", bank_col, k);
            wr_data = 4'(k + 1);
            @(negedge clk);
        end
        chk("wr_done_dir", bank_rd_o_wr, 0);
        chk("wr_done_req", wr_data_req, 0);
        chk("wr_done_ready", cmd_ready, 1);
        chk("wr_done_col", bank_col, 7);

        exp_col = '{10'd0, 10'd1, 10'd2, 10'd3,
                    10'd4, 10'd5, 10'd6, 10'd7};
        exp_dat = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        do_read(10'd0);

        send(OP_WR, 17'd0, 10'd16);
        for (int k = 0; k < 3; k++) begin
            wr_data = 4'hF;
            @(negedge clk);
        end
        chk("mid_wr_dir", bank_rd_o_wr, 1);
        chk("mid_wr_col", bank_col, 19);
        reset_n = 1'b0;
        #1;
        chk("abort_dir", bank_rd_o_wr, 0);
        chk("abort_req", wr_data_req, 0);
        chk("abort_row_open", row_open, 0);
        chk("abort_ready", cmd_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("release_ready", cmd_ready, 1);
        chk("release_row_open", row_open, 0);
        chk("release_rd_valid", rd_valid, 0);

        send(OP_ACT, 17'd7, 10'd0);
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        chk("act7_ready", cmd_ready, 1);
        chk("act7_row", bank_row, 7);

        send(OP_PRE, 17'd0, 10'd0);
        chk("pre_row_open", row_open, 0);
        chk("pre_ready", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_op    = OP_ACT;
        cmd_row   = 17'd9;
        cnt = 1;
        while (!cmd_ready && cnt < 20) begin
            @(negedge clk);
            if (!cmd_ready) cnt++;
        end
        chk("pre_trp_stall", cnt, 4);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("act9_row_open", row_open, 1);
        chk("act9_bank_row", bank_row, 9);
        chk("act9_ready", cmd_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
